// File: rtl/acond_pkg.sv
//------------------------------------------------------------------------------
// Module   : acond_pkg
// Brief    : Shared state encoding and default timing constants for the
//            pedestrian push-button conditioning block.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package acond_pkg;

   // 2'd3 is unused; the request FSM recovers from it to IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      LOCK = 2'd2
   } estado_t;

   localparam int unsigned c_DEB_CYCLES  = 1_000_000;    // 20 ms @ 50 MHz
   localparam int unsigned c_LOCK_CYCLES = 500_000_000;  // 10 s @ 50 MHz
   localparam int unsigned c_CNT_W       = 29;

endpackage : acond_pkg

`default_nettype wire

// File: rtl/acond_botones_antirrebote.sv
//------------------------------------------------------------------------------
// Module   : antirrebote
// Brief    : Two-flop synchronizer, debounce filter and rising-edge strobe
//            for one raw push-button.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module antirrebote
   import acond_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = c_DEB_CYCLES,
   parameter int unsigned CNT_W      = c_CNT_W
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic raw_i,
   output logic estable_o,
   output logic pulso_o
);

   localparam logic [CNT_W-1:0] c_DEB_MAX = CNT_W'(DEB_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_estable;
   logic             r_estable_q;
   logic [CNT_W-1:0] r_deb_cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= raw_i;
         r_sync2 <= r_sync1;
      end
   end

   // Any cycle agreeing with the accepted level restarts the hold count.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_estable <= 1'b0;
         r_deb_cnt <= '0;
      end else if (r_sync2 != r_estable) begin
         if (r_deb_cnt == c_DEB_MAX) begin
            r_estable <= r_sync2;
            r_deb_cnt <= '0;
         end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
         end
      end else begin
         r_deb_cnt <= '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_estable_q <= 1'b0;
      end else begin
         r_estable_q <= r_estable;
      end
   end

   assign estable_o = r_estable;
   assign pulso_o   = r_estable & ~r_estable_q;

endmodule : antirrebote

`default_nettype wire

// File: rtl/acond_botones.sv
//------------------------------------------------------------------------------
// Module   : acond_botones
// Brief    : Conditions both pedestrian buttons into clean request levels with
//            acknowledge handshake and post-acknowledge lockout.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module acond_botones
   import acond_pkg::*;
#(
   parameter int unsigned DEB_CYCLES  = c_DEB_CYCLES,
   parameter int unsigned LOCK_CYCLES = c_LOCK_CYCLES,
   parameter int unsigned CNT_W       = c_CNT_W
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic boton_1_i,
   input  logic boton_2_i,
   input  logic ack_1_i,
   input  logic ack_2_i,
   output logic req_1_o,
   output logic req_2_o,
   output logic pulso_1_o,
   output logic pulso_2_o
);

   localparam logic [CNT_W-1:0] c_LOCK_MAX = CNT_W'(LOCK_CYCLES - 1);

   logic [1:0] w_boton;
   logic [1:0] w_ack;
   logic [1:0] w_pulso;
   logic [1:0] w_req;
   logic [1:0] w_estable_unused;

   assign w_boton = {boton_2_i, boton_1_i};
   assign w_ack   = {ack_2_i, ack_1_i};

   for (genvar i = 0; i < 2; i++) begin : g_canal
      estado_t          r_estado;
      estado_t          w_estado_sig;
      logic [CNT_W-1:0] r_lock_cnt;

      antirrebote #(
         .DEB_CYCLES (DEB_CYCLES),
         .CNT_W      (CNT_W)
      ) u_antirrebote (
         .clk_i     (clk_i),
         .rst_ni    (rst_ni),
         .raw_i     (w_boton[i]),
         .estable_o (w_estable_unused[i]),
         .pulso_o   (w_pulso[i])
      );

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_estado <= IDLE;
         end else begin
            r_estado <= w_estado_sig;
         end
      end

      // Held at zero outside LOCK, so every LOCK entry starts a fresh count.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_lock_cnt <= '0;
         end else if (r_estado == LOCK) begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
         end else begin
            r_lock_cnt <= '0;
         end
      end

      always_comb begin
         w_estado_sig = r_estado;
         case (r_estado)
            IDLE:    if (w_pulso[i])                w_estado_sig = PEND;
            PEND:    if (w_ack[i])                  w_estado_sig = LOCK;
            LOCK:    if (r_lock_cnt == c_LOCK_MAX)  w_estado_sig = IDLE;
            default:                                w_estado_sig = IDLE;
         endcase
      end

      always_comb begin
         w_req[i] = (r_estado == PEND);
      end
   end : g_canal

   assign req_1_o   = w_req[0];
   assign req_2_o   = w_req[1];
   assign pulso_1_o = w_pulso[0];
   assign pulso_2_o = w_pulso[1];

endmodule : acond_botones

`default_nettype wire

// File: tb/tb_acond_botones.sv
//------------------------------------------------------------------------------
// Module   : tb_acond_botones
// Brief    : Directed self-checking bench for acond_botones (DEB=4, LOCK=8).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_acond_botones;

   logic clk_i = 1'b0;
   logic rst_ni;
   logic boton_1_i;
   logic boton_2_i;
   logic ack_1_i;
   logic ack_2_i;
   logic req_1_o;
   logic req_2_o;
   logic pulso_1_o;
   logic pulso_2_o;

   int n_checks = 0;
   int n_errors = 0;
   int p1;
   int p2;
   int p_acc;

   acond_botones #(
      .DEB_CYCLES  (4),
      .LOCK_CYCLES (8),
      .CNT_W       (4)
   ) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .boton_1_i (boton_1_i),
      .boton_2_i (boton_2_i),
      .ack_1_i   (ack_1_i),
      .ack_2_i   (ack_2_i),
      .req_1_o   (req_1_o),
      .req_2_o   (req_2_o),
      .pulso_1_o (pulso_1_o),
      .pulso_2_o (pulso_2_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic cuenta(input int n, output int c1, output int c2);
      c1 = 0;
      c2 = 0;
      repeat (n) begin
         @(posedge clk_i);
         #1;
         c1 += int'(pulso_1_o);
         c2 += int'(pulso_2_o);
      end
   endtask

   initial begin
      rst_ni    = 1'b0;
      boton_1_i = 1'b0;
      boton_2_i = 1'b0;
      ack_1_i   = 1'b0;
      ack_2_i   = 1'b0;
      #3;
      chk("reset_async_outs", {28'd0, req_2_o, req_1_o, pulso_2_o, pulso_1_o}, 32'd0);
      step(2);
      rst_ni = 1'b1;
      step(2);
      chk("reset_req", {30'd0, req_2_o, req_1_o}, 32'd0);
      chk("reset_pulso", {30'd0, pulso_2_o, pulso_1_o}, 32'd0);

      // 1: clean press
      boton_1_i = 1'b1;
      cuenta(5, p1, p2);
      chk("t1_no_early_pulse", p1, 0);
      step(1);
      chk("t1_pulso_edge6", pulso_1_o, 1);
      chk("t1_req_not_yet", req_1_o, 0);
      step(1);
      chk("t1_pulso_one_cycle", pulso_1_o, 0);
      chk("t1_req_rise", req_1_o, 1);
      chk("t1_req2_idle", req_2_o, 0);
      cuenta(12, p1, p2);
      chk("t1_no_repeat", p1, 0);
      chk("t1_ch2_quiet", p2, 0);
      chk("t1_req_held", req_1_o, 1);

      // 6a: release produces no pulse
      boton_1_i = 1'b0;
      cuenta(10, p1, p2);
      chk("t6_release_no_pulse", p1, 0);
      chk("t6_release_req_kept", req_1_o, 1);

      // 2: bounce, then settle high
      p_acc = 0;
      for (int i = 0; i < 6; i++) begin
         boton_1_i = ((i % 2) == 0);
         cuenta(2, p1, p2);
         p_acc += p1;
      end
      chk("t2_bounce_no_pulse", p_acc, 0);
      boton_1_i = 1'b1;
      cuenta(5, p1, p2);
      chk("t2_settle_no_early", p1, 0);
      step(1);
      chk("t2_settle_pulse", pulso_1_o, 1);
      step(1);
      chk("t2_pulse_single", pulso_1_o, 0);
      chk("t2_pend_kept", req_1_o, 1);

      // 3: handshake, press landing in last lock cycle is discarded
      boton_1_i = 1'b0;
      step(8);
      ack_1_i = 1'b1;
      step(1);
      ack_1_i = 1'b0;
      chk("t3_req_fall", req_1_o, 0);
      step(1);
      boton_1_i = 1'b1;
      cuenta(5, p1, p2);
      chk("t3_no_early_pulse", p1, 0);
      step(1);
      chk("t3_pulse_in_lock", pulso_1_o, 1);
      chk("t3_req_in_lock", req_1_o, 0);
      step(2);
      chk("t3_lock_pulse_dropped", req_1_o, 0);
      boton_1_i = 1'b0;
      step(8);
      boton_1_i = 1'b1;
      step(6);
      chk("t3_repress_pulse", pulso_1_o, 1);
      step(1);
      chk("t3_repress_req", req_1_o, 1);

      // 6c: ack held 5 cycles, pulse on first IDLE cycle is accepted
      boton_1_i = 1'b0;
      step(8);
      ack_1_i = 1'b1;
      step(1);
      chk("t6_ack_held_fall", req_1_o, 0);
      step(2);
      boton_1_i = 1'b1;
      step(2);
      ack_1_i = 1'b0;
      step(4);
      chk("t6_lock_end_pulse", pulso_1_o, 1);
      chk("t6_lock_end_req_low", req_1_o, 0);
      step(1);
      chk("t6_single_lock_entry", req_1_o, 1);

      boton_1_i = 1'b0;
      ack_1_i   = 1'b1;
      step(1);
      ack_1_i = 1'b0;
      chk("cleanup_req1_low", req_1_o, 0);
      step(10);

      // 6b: ack in IDLE is ignored
      ack_2_i = 1'b1;
      step(3);
      ack_2_i = 1'b0;
      chk("t6_ack_idle", req_2_o, 0);

      // 4: independence, plus pulse and ack together in IDLE
      boton_1_i = 1'b1;
      boton_2_i = 1'b1;
      step(5);
      ack_2_i = 1'b1;
      step(1);
      chk("t4_pulso1", pulso_1_o, 1);
      chk("t4_pulso2", pulso_2_o, 1);
      step(1);
      ack_2_i = 1'b0;
      chk("t4_req1", req_1_o, 1);
      chk("t4_req2_pulse_ack_idle", req_2_o, 1);
      step(2);
      chk("t4_req2_ack_ignored", req_2_o, 1);
      ack_2_i = 1'b1;
      step(1);
      ack_2_i = 1'b0;
      chk("t4_req2_fall", req_2_o, 0);
      chk("t4_req1_stays", req_1_o, 1);

      // 5: asynchronous reset with buttons held
      rst_ni = 1'b0;
      #1;
      chk("t5_async_req", {30'd0, req_2_o, req_1_o}, 32'd0);
      chk("t5_async_pulso", {30'd0, pulso_2_o, pulso_1_o}, 32'd0);
      step(2);
      rst_ni = 1'b1;
      cuenta(5, p1, p2);
      chk("t5_no_early_pulse", p1, 0);
      step(1);
      chk("t5_repulse1", pulso_1_o, 1);
      chk("t5_repulse2", pulso_2_o, 1);
      step(1);
      chk("t5_req1", req_1_o, 1);
      chk("t5_req2", req_2_o, 1);
      cuenta(6, p1, p2);
      chk("t5_single_pulse", p1, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_acond_botones

`default_nettype wire
